// File: rtl/seq_ctrl_pkg.sv
// Shared types, widths and field-position helpers for the sequencing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package seq_ctrl_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NOOP  = 4'd0,
        OP_LOAD  = 4'd1,
        OP_STORE = 4'd2,
        OP_JMP   = 4'd3,
        OP_BZ    = 4'd4,
        OP_HALT  = 4'd5,
        OP_RSV6  = 4'd6,
        OP_RSV7  = 4'd7
    } opcode_e;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_LOAD2  = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    // How the instruction pointer moves at the end of the current cycle.
    typedef enum logic [1:0] {
        IP_HOLD = 2'd0,
        IP_INC  = 2'd1,
        IP_JMP  = 2'd2,
        IP_BR   = 2'd3
    } ip_sel_e;

    // Field positions within the instruction register (ra always sits at bit 0).
    function automatic int op_lsb(input int width);
        return width - OP_W;
    endfunction

    function automatic int rb_lsb(input int r_addr_w);
        return r_addr_w;
    endfunction

    function automatic int rw_lsb(input int r_addr_w);
        return 2 * r_addr_w;
    endfunction

    function automatic int daddr_lsb(input int r_addr_w);
        return r_addr_w;
    endfunction

    function automatic int off_lsb(input int r_addr_w);
        return r_addr_w;
    endfunction

    // Opcodes 8-15 are all ALU operations; the low three bits pick the function.
    function automatic logic is_alu(input logic [OP_W-1:0] op);
        return op[OP_W-1];
    endfunction

    function automatic logic is_reserved(input logic [OP_W-1:0] op);
        return (op == OP_RSV6) || (op == OP_RSV7);
    endfunction

endpackage

// File: rtl/seq_ctrl_decode.sv
// Combinational decode of FSM state and instruction into datapath controls and ip move.
// Latency: zero cycles (pure combinational).
// Backpressure: none; outputs follow inputs every cycle.
module seq_ctrl_decode
    import seq_ctrl_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int D_ADDR_W = 8,
    parameter int R_ADDR_W = 4
) (
    input  logic [2:0]          state,
    input  logic [WIDTH-1:0]    ir,
    input  logic                alu_zero,
    output logic                D_wr,
    output logic                RF_s,
    output logic                RF_W_en,
    output logic [D_ADDR_W-1:0] D_addr,
    output logic [R_ADDR_W-1:0] RF_W_addr,
    output logic [R_ADDR_W-1:0] RF_A_addr,
    output logic [R_ADDR_W-1:0] RF_B_addr,
    output logic [3:0]          ALU_sel,
    output logic [1:0]          ip_sel
);

    logic [OP_W-1:0]     op;
    logic [R_ADDR_W-1:0] ra;
    logic [R_ADDR_W-1:0] rb;
    logic [R_ADDR_W-1:0] rw;
    logic [D_ADDR_W-1:0] daddr;

    assign op    = ir[op_lsb(WIDTH) +: OP_W];
    assign ra    = ir[R_ADDR_W-1:0];
    assign rb    = ir[rb_lsb(R_ADDR_W) +: R_ADDR_W];
    assign rw    = ir[rw_lsb(R_ADDR_W) +: R_ADDR_W];
    assign daddr = ir[daddr_lsb(R_ADDR_W) +: D_ADDR_W];

    // Everything idles at zero; only EXEC and LOAD2 drive the datapath.
    always_comb begin
        D_wr      = 1'b0;
        RF_s      = 1'b0;
        RF_W_en   = 1'b0;
        D_addr    = '0;
        RF_W_addr = '0;
        RF_A_addr = '0;
        RF_B_addr = '0;
        ALU_sel   = '0;
        ip_sel    = IP_HOLD;
        case (state_e'(state))
            S_DECODE: begin
                ip_sel = IP_INC;
            end
            S_EXEC: begin
                if (is_alu(op)) begin
                    RF_W_en   = 1'b1;
                    RF_W_addr = rw;
                    RF_A_addr = ra;
                    RF_B_addr = rb;
                    ALU_sel   = {1'b0, op[2:0]};
                end else begin
                    case (opcode_e'(op))
                        OP_LOAD: begin
                            // Address goes out now; the write lands in LOAD2.
                            D_addr = daddr;
                            RF_s   = 1'b1;
                        end
                        OP_STORE: begin
                            D_wr      = 1'b1;
                            D_addr    = daddr;
                            RF_A_addr = ra;
                        end
                        OP_JMP: begin
                            ip_sel = IP_JMP;
                        end
                        OP_BZ: begin
                            if (alu_zero) begin
                                ip_sel = IP_BR;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
            S_LOAD2: begin
                RF_W_en   = 1'b1;
                RF_s      = 1'b1;
                RF_W_addr = ra;
                D_addr    = daddr;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/seq_ctrl_mem.sv
// Single-port instruction/data storage with a registered read port.
// Latency: read data valid one cycle after the address is presented.
// Backpressure: none; accepts an access every cycle.
module seq_ctrl_mem #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

    // Optional write, then registered read of the same location (read-first).
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/seq_controller.sv
// Instruction sequencer: owns ip/ir/instruction memory, fetch-decode-execute FSM; SEQ_CTRL_TRAP_EN adds illegal-op trap.
// Latency: 3 cycles per instruction (FETCH, DECODE, EXEC), LOAD takes 4 (adds LOAD2).
// Backpressure: none; free-running until HALT, which holds until reset.
module seq_controller
    import seq_ctrl_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int D_ADDR_W = 8,
    parameter int I_ADDR_W = 7,
    parameter int R_ADDR_W = 4,
    parameter int BR_OFF_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_zero,
    output logic                D_wr,
    output logic                RF_s,
    output logic                RF_W_en,
    output logic [D_ADDR_W-1:0] D_addr,
    output logic [R_ADDR_W-1:0] RF_W_addr,
    output logic [R_ADDR_W-1:0] RF_A_addr,
    output logic [R_ADDR_W-1:0] RF_B_addr,
    output logic [3:0]          ALU_sel,
    output logic                halted,
    output logic [I_ADDR_W-1:0] ip_out,
    output logic [2:0]          state_out
`ifdef SEQ_CTRL_TRAP_EN
    ,
    output logic                illegal_op
`endif
);

    if ((WIDTH < OP_W + D_ADDR_W + R_ADDR_W) ||
        (WIDTH < OP_W + 3 * R_ADDR_W) ||
        (WIDTH < OP_W + R_ADDR_W + BR_OFF_W) ||
        (WIDTH < I_ADDR_W)) begin : g_bad_params
        $error("seq_controller: WIDTH too narrow for the instruction field layout");
    end

    state_e              state;
    state_e              state_nxt;
    logic [I_ADDR_W-1:0] ip;
    logic [WIDTH-1:0]    ir;
    logic [WIDTH-1:0]    imem_rdata;
    logic [OP_W-1:0]     op;
    logic [1:0]          ip_sel;
    logic [I_ADDR_W-1:0] off_ip;
    logic [I_ADDR_W-1:0] tgt;

    assign op  = ir[WIDTH-1 -: OP_W];
    assign tgt = ir[I_ADDR_W-1:0];

    // Branch offset brought to ip width: sign-extend if narrower, else keep
    // the low bits (addition wraps modulo the ip range either way).
    if (BR_OFF_W >= I_ADDR_W) begin : g_off_trunc
        assign off_ip = ir[off_lsb(R_ADDR_W) +: I_ADDR_W];
    end else begin : g_off_sext
        assign off_ip = {{(I_ADDR_W - BR_OFF_W){ir[off_lsb(R_ADDR_W) + BR_OFF_W - 1]}},
                         ir[off_lsb(R_ADDR_W) +: BR_OFF_W]};
    end

    // Instruction storage is read-only in this block; address tracks ip.
    seq_ctrl_mem #(
        .DATA_W (WIDTH),
        .ADDR_W (I_ADDR_W)
    ) u_imem (
        .clk   (clk),
        .we    (1'b0),
        .addr  (ip),
        .wdata ('0),
        .rdata (imem_rdata)
    );

    seq_ctrl_decode #(
        .WIDTH    (WIDTH),
        .D_ADDR_W (D_ADDR_W),
        .R_ADDR_W (R_ADDR_W)
    ) u_decode (
        .state     (state),
        .ir        (ir),
        .alu_zero  (alu_zero),
        .D_wr      (D_wr),
        .RF_s      (RF_s),
        .RF_W_en   (RF_W_en),
        .D_addr    (D_addr),
        .RF_W_addr (RF_W_addr),
        .RF_A_addr (RF_A_addr),
        .RF_B_addr (RF_B_addr),
        .ALU_sel   (ALU_sel),
        .ip_sel    (ip_sel)
    );

    // State register; reset aborts whatever instruction is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: fixed three-phase cycle, LOAD detours through LOAD2, HALT is sticky.
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:   state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                if (op == OP_LOAD) begin
                    state_nxt = S_LOAD2;
                end else if (op == OP_HALT) begin
                    state_nxt = S_HALT;
`ifdef SEQ_CTRL_TRAP_EN
                end else if (is_reserved(op)) begin
                    state_nxt = S_HALT;
`endif
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            S_LOAD2:  state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_INIT;
        endcase
    end

    // ir captures memory data in DECODE; ip moves as the decoder selects.
    always_ff @(posedge clk) begin
        if (reset) begin
            ip <= '0;
            ir <= '0;
        end else begin
            if (state == S_DECODE) begin
                ir <= imem_rdata;
            end
            case (ip_sel_e'(ip_sel))
                IP_INC:  ip <= ip + I_ADDR_W'(1);
                IP_JMP:  ip <= tgt;
                IP_BR:   ip <= ip + off_ip;
                default: ip <= ip;
            endcase
        end
    end

`ifdef SEQ_CTRL_TRAP_EN
    // Sticky flag for a reserved opcode reaching EXEC; ip already points past it.
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_op <= 1'b0;
        end else if ((state == S_EXEC) && is_reserved(op)) begin
            illegal_op <= 1'b1;
        end
    end
`endif

    assign halted    = (state == S_HALT);
    assign ip_out    = ip;
    assign state_out = state;

endmodule

// File: tb/tb_seq_controller.sv
// Directed bench: instruction-level model predicts every cycle, plus literal spot checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_seq_controller;
    import seq_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       alu_zero = 1'b0;
    logic       D_wr, RF_s, RF_W_en, halted;
    logic [7:0] D_addr;
    logic [3:0] RF_W_addr, RF_A_addr, RF_B_addr, ALU_sel;
    logic [6:0] ip_out;
    logic [2:0] state_out;
    logic       ill_obs;
`ifdef SEQ_CTRL_TRAP_EN
    logic       illegal_op;
    assign ill_obs = illegal_op;
`else
    assign ill_obs = 1'b0;
`endif

    seq_controller dut (
        .clk       (clk),
        .reset     (reset),
        .alu_zero  (alu_zero),
        .D_wr      (D_wr),
        .RF_s      (RF_s),
        .RF_W_en   (RF_W_en),
        .D_addr    (D_addr),
        .RF_W_addr (RF_W_addr),
        .RF_A_addr (RF_A_addr),
        .RF_B_addr (RF_B_addr),
        .ALU_sel   (ALU_sel),
        .halted    (halted),
        .ip_out    (ip_out),
        .state_out (state_out)
`ifdef SEQ_CTRL_TRAP_EN
        ,
        .illegal_op (illegal_op)
`endif
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic       d_wr;
        logic       rf_s;
        logic       rf_w_en;
        logic [7:0] d_addr;
        logic [3:0] w_addr;
        logic [3:0] a_addr;
        logic [3:0] b_addr;
        logic [3:0] alu_sel;
        logic       halted;
        logic       ill;
        logic [6:0] ip;
        logic [2:0] st;
    } obs_t;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] prog  [0:127];
    logic [15:0] nprog [0:127];
    obs_t        q[$];
    int          mip   = 0;
    logic        mhalt = 1'b0;
    logic        mill  = 1'b0;
    logic        rst_prev = 1'b0;
    logic        armed = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
        end
    endtask

    // Expand the next instruction into its per-cycle expected outputs.
    task automatic gen();
        obs_t             r;
        logic [15:0]      ins;
        logic signed [7:0] offv;
        int               op;
        int               nip;
        r = '0;
        r.ill = mill;
        r.ip  = 7'(mip);
        if (mhalt) begin
            r.halted = 1'b1;
            r.st     = S_HALT;
            q.push_back(r);
            return;
        end
        ins = prog[mip];
        op  = int'(ins[15:12]);
        r.st = S_FETCH;
        q.push_back(r);
        r.st = S_DECODE;
        q.push_back(r);
        nip  = (mip + 1) % 128;
        mip  = nip;
        r.ip = 7'(nip);
        r.st = S_EXEC;
        if (op >= 8) begin
            r.rf_w_en = 1'b1;
            r.w_addr  = ins[11:8];
            r.a_addr  = ins[3:0];
            r.b_addr  = ins[7:4];
            r.alu_sel = 4'(op - 8);
            q.push_back(r);
        end else begin
            case (op)
                1: begin
                    r.d_addr = ins[11:4];
                    r.rf_s   = 1'b1;
                    q.push_back(r);
                    r.st      = S_LOAD2;
                    r.rf_w_en = 1'b1;
                    r.w_addr  = ins[3:0];
                    q.push_back(r);
                end
                2: begin
                    r.d_wr   = 1'b1;
                    r.d_addr = ins[11:4];
                    r.a_addr = ins[3:0];
                    q.push_back(r);
                end
                3: begin
                    q.push_back(r);
                    mip = int'(ins[6:0]);
                end
                4: begin
                    q.push_back(r);
                    if (alu_zero) begin
                        offv = ins[11:4];
                        mip  = (nip + int'(offv) + 128) % 128;
                    end
                end
                5: begin
                    q.push_back(r);
                    mhalt = 1'b1;
                end
                6, 7: begin
                    q.push_back(r);
`ifdef SEQ_CTRL_TRAP_EN
                    mhalt = 1'b1;
                    mill  = 1'b1;
`endif
                end
                default: q.push_back(r);
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        rst_prev = reset;
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        obs_t exp_r;
        obs_t act_r;
        forever begin
            @(negedge clk);
            if (rst_prev) begin
                armed = 1'b1;
                q.delete();
                mip   = 0;
                mhalt = 1'b0;
                mill  = 1'b0;
                exp_r = '0;
                exp_r.st = S_INIT;
            end else if (armed) begin
                if (q.size() == 0) gen();
                exp_r = q.pop_front();
            end
            if (armed) begin
                act_r = {D_wr, RF_s, RF_W_en, D_addr, RF_W_addr, RF_A_addr, RF_B_addr,
                         ALU_sel, halted, ill_obs, ip_out, state_out};
                chk("model_cycle", 64'(act_r), 64'(exp_r));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 128; i++) nprog[i] = 16'h0000;
    endtask

    // Hold reset, install nprog, check the INIT cycle, then release.
    task automatic apply_reset(input logic az);
        reset = 1'b1;
        @(negedge clk);
        alu_zero = az;
        for (int i = 0; i < 128; i++) begin
            prog[i] = nprog[i];
            dut.u_imem.mem[i] <= nprog[i];
        end
        @(negedge clk);
        chk("init_state", 64'(state_out), 64'(S_INIT));
        chk("init_ip", 64'(ip_out), 64'd0);
        chk("init_halted", 64'(halted), 64'd0);
        chk("init_strobes", 64'({D_wr, RF_W_en, RF_s}), 64'd0);
        reset = 1'b0;
    endtask

    initial begin
        int   viol;
        logic found;

        // NOOP, ALU, LOAD, STORE, HALT
        clear_prog();
        nprog[0] = 16'h0000;
        nprog[1] = 16'h9321;
        nprog[2] = 16'h1A56;
        nprog[3] = 16'h2106;
        nprog[4] = 16'h5000;
        apply_reset(1'b0);
        tick(3);
        chk("ip_after_decode", 64'(ip_out), 64'd1);
        tick(1);
        chk("fetch_every_3", 64'(state_out), 64'(S_FETCH));
        tick(2);
        chk("alu_wen", 64'({RF_W_en, RF_s}), 64'b10);
        chk("alu_sel", 64'(ALU_sel), 64'd1);
        chk("alu_addrs", 64'({RF_W_addr, RF_A_addr, RF_B_addr}), 64'h312);
        tick(1);
        chk("alu_wen_pulse", 64'(RF_W_en), 64'd0);
        tick(2);
        chk("load_exec", 64'({D_addr, RF_W_en, RF_s}), 64'({8'hA5, 2'b01}));
        tick(1);
        chk("load2", 64'({D_addr, RF_W_en, RF_s, RF_W_addr}), 64'({8'hA5, 2'b11, 4'd6}));
        tick(1);
        chk("load2_over", 64'({RF_W_en, state_out}), 64'({1'b0, S_FETCH}));
        tick(2);
        chk("store_exec", 64'({D_wr, D_addr, RF_A_addr}), 64'({1'b1, 8'h10, 4'd6}));
        tick(1);
        chk("store_pulse", 64'({D_wr, ip_out}), 64'({1'b0, 7'd4}));
        tick(3);
        chk("halt_entry", 64'({halted, ip_out}), 64'({1'b1, 7'd5}));
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (!halted || D_wr || RF_W_en) viol++;
        end
        chk("halt_hold_20", 64'(viol), 64'd0);

        // BZ -3 at address 10, taken then not taken
        clear_prog();
        nprog[0]  = 16'h300A;
        nprog[10] = 16'h4FD0;
        nprog[8]  = 16'h5000;
        nprog[11] = 16'h5000;
        apply_reset(1'b1);
        tick(4);
        chk("jmp_to_10", 64'(ip_out), 64'd10);
        tick(3);
        chk("bz_taken", 64'({state_out, ip_out}), 64'({S_FETCH, 7'd8}));
        tick(4);
        chk("bz_taken_halt", 64'({halted, ip_out}), 64'({1'b1, 7'd9}));
        apply_reset(1'b0);
        tick(7);
        chk("bz_not_taken", 64'({state_out, ip_out}), 64'({S_FETCH, 7'd11}));
        tick(4);
        chk("bz_nt_halt", 64'({halted, ip_out}), 64'({1'b1, 7'd12}));

        // JMP 127 then NOOP: ip wraps to 0
        clear_prog();
        nprog[0] = 16'h307F;
        apply_reset(1'b0);
        tick(4);
        chk("jmp_127", 64'(ip_out), 64'd127);
        tick(2);
        chk("ip_wrap", 64'(ip_out), 64'd0);
        tick(7);

        // Reset landing in LOAD2
        clear_prog();
        nprog[0] = 16'h1A56;
        apply_reset(1'b0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick(1);
            if (state_out == S_LOAD2) found = 1'b1;
        end
        chk("load2_reached", 64'(found), 64'd1);
        reset = 1'b1;
        tick(1);
        chk("rst_in_load2", 64'({RF_W_en, D_addr, state_out}), 64'({1'b0, 8'h00, S_INIT}));

        // Reserved opcode 6
        clear_prog();
        nprog[0] = 16'h6000;
        apply_reset(1'b0);
        tick(4);
`ifdef SEQ_CTRL_TRAP_EN
        chk("trap", 64'({ill_obs, halted, ip_out}), 64'({2'b11, 7'd1}));
`else
        chk("rsv_noop", 64'({halted, state_out, ip_out}), 64'({1'b0, S_FETCH, 7'd1}));
`endif
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
